// File: rtl/adder_result_display_if.sv
// Bus between the adder outputs and the result display stage.
// The master drives the adder result and the load request; the slave returns status and pins.
interface adder_result_display_if;
    logic [3:0] sum_in;
    logic       carry_in;
    logic       load;
    logic       busy;
    logic       done;
    logic [1:0] an;
    logic [6:0] seg;

    modport master (
        output sum_in,
        output carry_in,
        output load,
        input  busy,
        input  done,
        input  an,
        input  seg
    );

    modport slave (
        input  sum_in,
        input  carry_in,
        input  load,
        output busy,
        output done,
        output an,
        output seg
    );
endinterface

// File: rtl/adder_result_display.sv
// Captures the 5-bit adder result, converts it to two BCD digits with a sequential
// double-dabble engine, and scans them onto a 2-digit active-low 7-segment display.
module adder_result_display #(
    parameter int unsigned REFRESH_CNT = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_result_display_if.slave bus
);
    localparam int unsigned VAL_W  = 5;
    localparam int unsigned BCD_W  = 8;
    localparam int unsigned DD_W   = BCD_W + VAL_W;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SCAN_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(VAL_W - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(REFRESH_CNT - 1);

    localparam logic [1:0] AN_ONES   = 2'b10;
    localparam logic [1:0] AN_TENS   = 2'b01;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LATCH   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [VAL_W-1:0]  shift_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [1:0]        tens_q;
    logic [3:0]        ones_q;
    logic [SCAN_W-1:0] scan_q;
    logic              sel_tens_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        an_q;
    logic [6:0]        seg_q;

    logic              capture_c;
    logic              step_c;
    logic              latch_c;
    logic              busy_d;
    logic              done_d;
    logic [BCD_W-1:0]  bcd_adj_c;
    logic [DD_W-1:0]   dd_shifted_c;
    logic [1:0]        tens_d;
    logic [3:0]        ones_d;
    logic              sel_tens_d;
    logic [SCAN_W-1:0] scan_d;
    logic [1:0]        an_d;
    logic [6:0]        seg_d;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        add3 = (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a load outside IDLE is simply not looked at
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.load) state_d = CONVERT;
            CONVERT: if (bit_cnt_q == '0) state_d = LATCH;
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state controls and next values of the registered status outputs
    always_comb begin
        capture_c = 1'b0;
        step_c    = 1'b0;
        latch_c   = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                capture_c = bus.load;
                busy_d    = bus.load;
            end
            CONVERT: begin
                step_c = 1'b1;
                busy_d = 1'b1;
            end
            LATCH: begin
                latch_c = 1'b1;
                done_d  = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // One double-dabble iteration: correct each nibble, then shift the pair left
    always_comb begin
        bcd_adj_c    = {add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        dd_shifted_c = {bcd_adj_c, shift_q} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            if (capture_c) begin
                shift_q   <= {bus.carry_in, bus.sum_in};
                bcd_q     <= '0;
                bit_cnt_q <= LAST_BIT;
            end else if (step_c) begin
                {bcd_q, shift_q} <= dd_shifted_c;
                if (bit_cnt_q != '0) begin
                    bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                end
            end
            if (latch_c) begin
                tens_q <= bcd_q[5:4];
                ones_q <= bcd_q[3:0];
            end
        end
    end

    // Scan and pin drive are computed from next-cycle digits so a latch shows on the done edge
    always_comb begin
        tens_d     = latch_c ? bcd_q[5:4] : tens_q;
        ones_d     = latch_c ? bcd_q[3:0] : ones_q;
        scan_d     = (scan_q == SCAN_MAX) ? '0 : scan_q + SCAN_W'(1);
        sel_tens_d = (scan_q == SCAN_MAX) ? ~sel_tens_q : sel_tens_q;
        an_d       = AN_ONES;
        seg_d      = seg_code(ones_d);
        if (sel_tens_d) begin
            if (tens_d == 2'd0) begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end else begin
                an_d  = AN_TENS;
                seg_d = seg_code({2'b00, tens_d});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q     <= '0;
            sel_tens_q <= 1'b0;
            an_q       <= AN_ONES;
            seg_q      <= 7'b1000000;
        end else begin
            scan_q     <= scan_d;
            sel_tens_q <= sel_tens_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.an   = an_q;
    assign bus.seg  = seg_q;

endmodule

// File: tb/tb_adder_result_display.sv
// Randomized scoreboard bench for adder_result_display: loads push expected digits,
// a monitor checks done/busy timing and the scanned display every cycle.
module tb_adder_result_display;
    localparam int R   = 4;
    localparam int LAT = 6;

    logic clk = 1'b0;
    logic rst;

    adder_result_display_if bus ();

    adder_result_display #(.REFRESH_CNT(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    int cyc        = 0;
    int scan_k     = 0;
    int exp_tens   = 0;
    int exp_ones   = 0;
    int busy_start = -100;
    int q_val [$];
    int q_cyc [$];
    int n_checks   = 0;
    int n_fail     = 0;
    bit chk_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference time base and reset behaviour, advanced on every rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            scan_k     = 0;
            exp_tens   = 0;
            exp_ones   = 0;
            busy_start = -100;
            q_val.delete();
            q_cyc.delete();
        end else begin
            scan_k = scan_k + 1;
        end
    end

    // Monitor: pop expected results when due and check the pins
    bit         exp_done_c;
    bit         exp_busy_c;
    int         v_pop;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_done_c = (q_cyc.size() > 0) && (cyc == q_cyc[0] + LAT);
            exp_busy_c = (cyc >= busy_start) && (cyc < busy_start + LAT);
            check("done", 32'(bus.done), 32'(exp_done_c));
            check("busy", 32'(bus.busy), 32'(exp_busy_c));
            if (exp_done_c) begin
                v_pop = q_val.pop_front();
                void'(q_cyc.pop_front());
                exp_tens = v_pop / 10;
                exp_ones = v_pop % 10;
            end
            if (((scan_k / R) % 2) == 1) begin
                if (exp_tens == 0) begin
                    exp_an  = 2'b11;
                    exp_seg = 7'b1111111;
                end else begin
                    exp_an  = 2'b01;
                    exp_seg = seg_tab[exp_tens];
                end
            end else begin
                exp_an  = 2'b10;
                exp_seg = seg_tab[exp_ones];
            end
            check("an", 32'(bus.an), 32'(exp_an));
            check("seg", 32'(bus.seg), 32'(exp_seg));
        end
    end

    task automatic issue(input logic [4:0] v, input bit accept);
        @(negedge clk);
        bus.sum_in   = v[3:0];
        bus.carry_in = v[4];
        bus.load     = 1'b1;
        if (accept) begin
            q_val.push_back(int'(v));
            q_cyc.push_back(cyc + 1);
            busy_start = cyc + 1;
        end
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [4:0] v;
        int gap;
        rst          = 1'b1;
        bus.load     = 1'b0;
        bus.sum_in   = 4'd0;
        bus.carry_in = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(3);

        // 19, then watch several scan periods
        issue(5'd19, 1'b1);
        idle_cycles(LAT + 12);

        // 31 and 0 (tens blank)
        issue(5'd31, 1'b1);
        idle_cycles(LAT + 10);
        issue(5'd0, 1'b1);
        idle_cycles(LAT + 10);

        // Second load two cycles into a conversion is dropped
        issue(5'd19, 1'b1);
        issue(5'd5, 1'b0);
        idle_cycles(LAT + 10);

        // Reset three edges into a conversion
        issue(5'd31, 1'b1);
        idle_cycles(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(LAT + 8);

        // Reset and load together
        @(negedge clk);
        rst          = 1'b1;
        bus.load     = 1'b1;
        bus.sum_in   = 4'd3;
        bus.carry_in = 1'b1;
        q_val.push_back(19);
        q_cyc.push_back(cyc + 1);
        @(negedge clk);
        rst      = 1'b0;
        bus.load = 1'b0;
        idle_cycles(LAT + 8);

        // Random values with input churn and stray loads while busy
        for (int i = 0; i < 24; i++) begin
            v = 5'($urandom_range(0, 31));
            issue(v, 1'b1);
            gap = LAT + int'($urandom_range(0, 8));
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                bus.sum_in   = 4'($urandom);
                bus.carry_in = 1'($urandom);
                bus.load     = (j < 5) && ($urandom_range(0, 3) == 0);
            end
            bus.load = 1'b0;
        end

        idle_cycles(LAT + 6);
        check("queue_empty", 32'(q_val.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
